// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: run enable plus raster timing outputs between the generator and its consumers.
interface lcd_timing_gen_if;
    logic        en;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    logic        line_start;
    logic        frame_start;
    modport master (
        input  en,
        output hs, vs, de, x, y, line_start, frame_start
    );
    modport slave (
        output en,
        input  hs, vs, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD/VGA raster timing generator producing HS, VS, DE, pixel coordinates and start pulses.
// Every output is registered from the current counter position, one clock behind the counters.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 13,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lcd_timing_gen_if.master lcd
);
    localparam logic [15:0] L_H_SYNC   = 16'(H_SYNC);
    localparam logic [15:0] L_H_DE_BEG = 16'(H_SYNC + H_BP);
    localparam logic [15:0] L_H_DE_END = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] L_H_LAST   = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [15:0] L_V_SYNC   = 16'(V_SYNC);
    localparam logic [15:0] L_V_DE_BEG = 16'(V_SYNC + V_BP);
    localparam logic [15:0] L_V_DE_END = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] L_V_LAST   = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_h_last;
    logic        w_v_last;
    logic [15:0] w_h_nxt;
    logic [15:0] w_v_nxt;
    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_de;
    logic [15:0] w_x;
    logic [15:0] w_y;

    always_comb begin
        w_h_last = (r_h_cnt == L_H_LAST);
        w_v_last = (r_v_cnt == L_V_LAST);
        // dropping EN abandons the raster so the next run always starts at the origin
        w_h_nxt  = !lcd.en ? 16'd0 : w_h_last ? 16'd0 : r_h_cnt + 16'd1;
        w_v_nxt  = !lcd.en ? 16'd0 :
                   w_h_last ? (w_v_last ? 16'd0 : r_v_cnt + 16'd1) : r_v_cnt;
        w_hs_act = (r_h_cnt < L_H_SYNC);
        w_vs_act = (r_v_cnt < L_V_SYNC);
        w_de     = (r_h_cnt >= L_H_DE_BEG) && (r_h_cnt < L_H_DE_END) &&
                   (r_v_cnt >= L_V_DE_BEG) && (r_v_cnt < L_V_DE_END);
        w_x      = w_de ? r_h_cnt - L_H_DE_BEG : 16'd0;
        w_y      = w_de ? r_v_cnt - L_V_DE_BEG : 16'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt       <= 16'd0;
            r_v_cnt       <= 16'd0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_de          <= 1'b0;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_hs          <= (lcd.en && w_hs_act) ? HS_POL : ~HS_POL;
            r_vs          <= (lcd.en && w_vs_act) ? VS_POL : ~VS_POL;
            r_de          <= lcd.en && w_de;
            r_x           <= lcd.en ? w_x : 16'd0;
            r_y           <= lcd.en ? w_y : 16'd0;
            r_line_start  <= lcd.en && (r_h_cnt == 16'd0);
            r_frame_start <= lcd.en && (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
        end
    end

    assign lcd.hs          = r_hs;
    assign lcd.vs          = r_vs;
    assign lcd.de          = r_de;
    assign lcd.x           = r_x;
    assign lcd.y           = r_y;
    assign lcd.line_start  = r_line_start;
    assign lcd.frame_start = r_frame_start;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed checks of the raster generator with a 14x7 test raster.
// Expected values come from the raster position index (h = idx % 14, v = idx / 14).
module tb_lcd_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   de_cnt, ls_cnt, vs_cnt, hs_cnt, fs_cnt;

    lcd_timing_gen_if bus();

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .lcd     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".hs"}, 32'(bus.hs), 0);
        chk({tag, ".vs"}, 32'(bus.vs), 0);
        chk({tag, ".de"}, 32'(bus.de), 0);
        chk({tag, ".x"}, 32'(bus.x), 0);
        chk({tag, ".y"}, 32'(bus.y), 0);
        chk({tag, ".ls"}, 32'(bus.line_start), 0);
        chk({tag, ".fs"}, 32'(bus.frame_start), 0);
    endtask

    task automatic pos_chk(input int idx);
        int h, v;
        logic de;
        string t;
        h  = idx % 14;
        v  = idx / 14;
        de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
        t  = $sformatf("pos%0d", idx);
        chk({t, ".hs"}, 32'(bus.hs), 32'(h < 2));
        chk({t, ".vs"}, 32'(bus.vs), 32'(v < 1));
        chk({t, ".de"}, 32'(bus.de), 32'(de));
        chk({t, ".x"}, 32'(bus.x), de ? 32'(h - 4) : 0);
        chk({t, ".y"}, 32'(bus.y), de ? 32'(v - 2) : 0);
        chk({t, ".ls"}, 32'(bus.line_start), 32'(h == 0));
        chk({t, ".fs"}, 32'(bus.frame_start), 32'(idx == 0));
        de_cnt += int'(bus.de);
        ls_cnt += int'(bus.line_start);
        vs_cnt += int'(bus.vs);
        hs_cnt += int'(bus.hs);
        fs_cnt += int'(bus.frame_start);
    endtask

    task automatic run(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pos_chk(from + i);
        end
    endtask

    task automatic clr_counts();
        de_cnt = 0;
        ls_cnt = 0;
        vs_cnt = 0;
        hs_cnt = 0;
        fs_cnt = 0;
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, ".de_cycles"}, 32'(de_cnt), 32);
        chk({tag, ".line_starts"}, 32'(ls_cnt), 7);
        chk({tag, ".vs_cycles"}, 32'(vs_cnt), 14);
        chk({tag, ".hs_cycles"}, 32'(hs_cnt), 14);
        chk({tag, ".frame_starts"}, 32'(fs_cnt), 1);
    endtask

    initial begin
        bus.en = 1'b1;
        rst_n  = 1'b0;
        repeat (3) tick();
        idle_chk("reset");
        rst_n = 1'b1;
        clr_counts();
        run(0, 98);
        frame_counts("frame1");
        // frame wrap: the 99th cycle is position (0,0) again
        run(0, 1);
        run(1, 48);
        bus.en = 1'b0;
        tick();
        idle_chk("en_low");
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_chk("en_hold");
        end
        bus.en = 1'b1;
        run(0, 38);
        chk("pre_rst.de", 32'(bus.de), 1);
        chk("pre_rst.x", 32'(bus.x), 5);
        rst_n = 1'b0;
        #2;
        idle_chk("async_rst");
        tick();
        idle_chk("rst_hold");
        rst_n = 1'b1;
        clr_counts();
        run(0, 98);
        frame_counts("frame2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
